// File: rtl/forwarding_hazard_unit.sv
// Forwarding-select and load-use hazard control for the 16-bit, 8-register pipelined core.
// Shadows the in-flight writers of the datapath and advances them in lockstep with its pipeline registers.
module forwarding_hazard_unit #(
   parameter int REG_W = 3,
   parameter int CNT_W = 16
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_uses_rs,
   input  logic             id_uses_rt,
   input  logic [REG_W-1:0] id_dest,
   input  logic             id_regwrite,
   input  logic             id_memread,
   input  logic             flush,
   input  logic             mem_wait,
   output logic [1:0]       forwardA,
   output logic [1:0]       forwardB,
   output logic             stall,
   output logic             bubble,
   output logic [CNT_W-1:0] stall_count
);

   typedef struct packed {
      logic             valid;
      logic [REG_W-1:0] dest;
      logic             regwrite;
      logic             memread;
   } slot_t;

   typedef enum logic [0:0] {
      RUN   = 1'b0,
      STALL = 1'b1
   } state_e;

   localparam logic [1:0]       FWD_RF  = 2'b00;
   localparam logic [1:0]       FWD_MEM = 2'b10;
   localparam logic [1:0]       FWD_WB  = 2'b01;
   localparam logic [REG_W-1:0] R0      = {REG_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam slot_t            EMPTY   = '{valid: 1'b0, dest: R0, regwrite: 1'b0, memread: 1'b0};

   // A writer in WB needs no bypass (the bank writes before it reads), so only EX and MEM are shadowed.
   slot_t            ex_q, ex_d, mem_q, mem_d;
   logic [1:0]       fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             hit_rs_s, hit_rt_s, hz_s;

   function automatic logic writes_reg(input slot_t s, input logic [REG_W-1:0] r);
      return s.valid & s.regwrite & (s.dest != R0) & (s.dest == r);
   endfunction

   // The EX producer wins over MEM; a load still in EX has no result yet and cannot be bypassed.
   function automatic logic [1:0] fwd_sel(input logic used, input logic [REG_W-1:0] src,
                                          input slot_t ex, input slot_t mem);
      logic [1:0] sel;
      sel = FWD_RF;
      if (!used) begin
         sel = FWD_RF;
      end else if (writes_reg(ex, src) && !ex.memread) begin
         sel = FWD_MEM;
      end else if (writes_reg(mem, src)) begin
         sel = FWD_WB;
      end else begin
         sel = FWD_RF;
      end
      return sel;
   endfunction

   // Load-use hazard: the decode instruction reads the destination of a load sitting in EX.
   always_comb begin
      hit_rs_s = id_uses_rs & writes_reg(ex_q, id_rs);
      hit_rt_s = id_uses_rt & writes_reg(ex_q, id_rt);
      hz_s     = id_valid & ex_q.memread & (hit_rs_s | hit_rt_s);
   end

   assign stall  = reset_n & hz_s & ~flush & ~mem_wait;
   assign bubble = reset_n & (hz_s | flush) & ~mem_wait;

   // Next-state: shadow slots, operand selects, FSM and stall counter.
   always_comb begin
      ex_d    = ex_q;
      mem_d   = mem_q;
      fwd_a_d = fwd_a_q;
      fwd_b_d = fwd_b_q;
      state_d = state_q;
      cnt_d   = cnt_q;
      if (mem_wait) begin
         state_d = state_q;
      end else begin
         mem_d = ex_q;
         if (flush || hz_s) begin
            ex_d    = EMPTY;
            fwd_a_d = FWD_RF;
            fwd_b_d = FWD_RF;
         end else begin
            ex_d    = '{valid: id_valid, dest: id_dest, regwrite: id_regwrite, memread: id_memread};
            fwd_a_d = id_valid ? fwd_sel(id_uses_rs, id_rs, ex_q, mem_q) : FWD_RF;
            fwd_b_d = id_valid ? fwd_sel(id_uses_rt, id_rt, ex_q, mem_q) : FWD_RF;
         end
         if (flush) begin
            state_d = RUN;
         end else begin
            case (state_q)
               RUN:     state_d = hz_s ? STALL : RUN;
               STALL:   state_d = RUN;
               default: state_d = RUN;
            endcase
         end
         if (hz_s && !flush && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
         end else begin
            cnt_d = cnt_q;
         end
      end
   end

   // State registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ex_q    <= EMPTY;
         mem_q   <= EMPTY;
         fwd_a_q <= FWD_RF;
         fwd_b_q <= FWD_RF;
         state_q <= RUN;
         cnt_q   <= {CNT_W{1'b0}};
      end else begin
         ex_q    <= ex_d;
         mem_q   <= mem_d;
         fwd_a_q <= fwd_a_d;
         fwd_b_q <= fwd_b_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign forwardA    = fwd_a_q;
   assign forwardB    = fwd_b_q;
   assign stall_count = cnt_q;

endmodule
